// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared opcodes, ALU operations and constants for the RV32I core
// Revision    : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [31:0] OUTPORT_ADDR = 32'hFFFF_FFFC;
    localparam int          IMEM_WORDS   = 512;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_IMM    = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_STORE  = 7'b0100011
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_e;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_SW   = 3'b010;

    // alt is instr[30]; it selects SUB only for register-register ops.
    function automatic alu_op_e decode_alu_op(input logic [2:0] f3, input logic alt,
                                              input logic is_reg);
        case (f3)
            F3_ADD:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_alu.sv
// ============================================================================
// Module      : riscv_alu
// Description : Combinational ALU with branch compare flags
// Revision    : 1.0
// ============================================================================
`default_nettype none

module riscv_alu
    import riscv_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] result,
    output logic        eq,
    output logic        lt,
    output logic        ltu
);

    logic [4:0] shamt;

    assign shamt = b[4:0];
    assign eq    = (a == b);
    assign lt    = ($signed(a) < $signed(b));
    assign ltu   = (a < b);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {31'd0, lt};
            ALU_SLTU: result = {31'd0, ltu};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/riscv_top.sv
// ============================================================================
// Module      : riscv_top
// Description : Single-cycle RV32I-subset core with flash-loaded imem and outport
// Revision    : 1.0
// ============================================================================
`default_nettype none

module riscv_top
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] flash_addr,
    input  logic [WIDTH-1:0] flash_data,
    input  logic             flash_en,
    output logic [WIDTH-1:0] outport
);

    // Contents survive rst; only the flash port ever changes them.
    logic [31:0] imem [IMEM_WORDS] = '{default: '0};
    logic [31:0] regs [32];
    logic [31:0] pc;

    logic [31:0] instr, rs1_val, rs2_val, pc_plus4;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    opcode_e     opcode;

    logic [31:0] alu_a, alu_b, alu_res, wb_data, next_pc, store_addr;
    alu_op_e     alu_op;
    logic        alu_eq, alu_lt, alu_ltu;
    logic        wb_en, out_we, take;
    logic        unused_flash_bits;

    assign unused_flash_bits = ^{flash_addr[31:11], flash_addr[1:0]};

    always_ff @(posedge clk) begin
        if (flash_en) begin
            imem[flash_addr[10:2]] <= flash_data;
        end
    end

    assign instr    = imem[pc[10:2]];
    assign opcode   = opcode_e'(instr[6:0]);
    assign rd       = instr[11:7];
    assign f3       = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign pc_plus4 = pc + 32'd4;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign store_addr = rs1_val + imm_s;

    riscv_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_res),
        .eq     (alu_eq),
        .lt     (alu_lt),
        .ltu    (alu_ltu)
    );

    always_comb begin
        case (f3)
            F3_BEQ:  take = alu_eq;
            F3_BNE:  take = !alu_eq;
            F3_BLT:  take = alu_lt;
            F3_BGE:  take = !alu_lt;
            F3_BLTU: take = alu_ltu;
            F3_BGEU: take = !alu_ltu;
            default: take = 1'b0;
        endcase
    end

    // Unknown opcodes fall through the defaults and behave as a NOP.
    always_comb begin
        alu_a   = rs1_val;
        alu_b   = rs2_val;
        alu_op  = ALU_ADD;
        wb_en   = 1'b0;
        wb_data = alu_res;
        next_pc = pc_plus4;
        out_we  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                wb_en   = 1'b1;
                wb_data = imm_u;
            end
            OPC_AUIPC: begin
                wb_en   = 1'b1;
                wb_data = pc + imm_u;
            end
            OPC_JAL: begin
                wb_en   = 1'b1;
                wb_data = pc_plus4;
                next_pc = pc + imm_j;
            end
            OPC_JALR: begin
                wb_en   = 1'b1;
                wb_data = pc_plus4;
                next_pc = (rs1_val + imm_i) & ~32'd1;
            end
            OPC_BRANCH: begin
                if (take) next_pc = pc + imm_b;
            end
            OPC_IMM: begin
                alu_b  = imm_i;
                alu_op = decode_alu_op(f3, instr[30], 1'b0);
                wb_en  = 1'b1;
            end
            OPC_OP: begin
                alu_op = decode_alu_op(f3, instr[30], 1'b1);
                wb_en  = 1'b1;
            end
            OPC_STORE: begin
                out_we = (f3 == F3_SW) && (store_addr == OUTPORT_ADDR);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= '0;
            outport <= '0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            pc <= next_pc;
            if (out_we) outport <= rs2_val;
            if (wb_en && (rd != 5'd0)) regs[rd] <= wb_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_riscv_top.sv
// ============================================================================
// Module      : tb_riscv_top
// Description : Directed self-checking bench for riscv_top
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_riscv_top;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] flash_addr = '0;
    logic [31:0] flash_data = '0;
    logic        flash_en = 1'b0;
    logic [31:0] outport;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    riscv_top dut (
        .clk        (clk),
        .rst        (rst),
        .flash_addr (flash_addr),
        .flash_data (flash_data),
        .flash_en   (flash_en),
        .outport    (outport)
    );

    // Holds reset and writes all 12 words so leftovers from earlier programs are cleared.
    task automatic load_prog(input logic [31:0] prog [12]);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            flash_en   = 1'b1;
            flash_addr = 32'(i * 4);
            flash_data = prog[i];
            @(negedge clk);
        end
        flash_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (outport !== 32'd0) begin
                errors++;
                $display("FAIL reset_outport got=%h exp=%h", outport, 32'd0);
            end
            checks++;
            if (dut.pc !== 32'd0) begin
                errors++;
                $display("FAIL reset_pc got=%h exp=%h", dut.pc, 32'd0);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (dut.pc !== 32'(k * 4)) begin
                errors++;
                $display("FAIL nop_fetch_pc step=%0d got=%h exp=%h", k, dut.pc, 32'(k * 4));
            end
        end
    endtask

    task automatic test_flash_run();
        logic [31:0] prog [12];
        prog = '{32'h00500613, 32'hFEC02E23, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        load_prog(prog);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (outport !== 32'd0) begin
            errors++;
            $display("FAIL flash_run_edge1 got=%h exp=%h", outport, 32'd0);
        end
        @(negedge clk);
        checks++;
        if (outport !== 32'd5) begin
            errors++;
            $display("FAIL flash_run_edge2 got=%h exp=%h", outport, 32'd5);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (outport !== 32'd5) begin
            errors++;
            $display("FAIL flash_run_hold got=%h exp=%h", outport, 32'd5);
        end
    endtask

    task automatic test_loop_jalr();
        logic [31:0] prog [12];
        logic [31:0] exp_pc  [8];
        logic [31:0] exp_x12 [8];
        prog    = '{32'h00c64633, 32'h00160613, 32'hffc00067, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_pc  = '{32'h4, 32'h8, 32'hFFFFFFFC, 32'h0, 32'h4, 32'h8, 32'hFFFFFFFC, 32'h0};
        exp_x12 = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd0, 32'd1, 32'd1, 32'd1};
        load_prog(prog);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (dut.pc !== exp_pc[k]) begin
                errors++;
                $display("FAIL loop_pc step=%0d got=%h exp=%h", k, dut.pc, exp_pc[k]);
            end
            checks++;
            if (dut.regs[12] !== exp_x12[k]) begin
                errors++;
                $display("FAIL loop_x12 step=%0d got=%h exp=%h", k, dut.regs[12], exp_x12[k]);
            end
        end
        checks++;
        if (dut.regs[0] !== 32'd0) begin
            errors++;
            $display("FAIL loop_x0 got=%h exp=%h", dut.regs[0], 32'd0);
        end
    endtask

    task automatic test_jal_branch();
        logic [31:0] prog [12];
        prog = '{32'h00700113, 32'hFE202E23, 32'h00300093, 32'hFFF08093,
                 32'hFE009EE3, 32'hFE102E23, 32'h008002EF, 32'hFE202E23,
                 32'h0000006F, 0, 0, 0};
        load_prog(prog);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (outport !== 32'd7) begin
            errors++;
            $display("FAIL branch_pre_store got=%h exp=%h", outport, 32'd7);
        end
        repeat (7) @(negedge clk);
        checks++;
        if (outport !== 32'd7 || dut.pc !== 32'd20) begin
            errors++;
            $display("FAIL branch_exit outport=%h pc=%h exp_outport=%h exp_pc=%h",
                     outport, dut.pc, 32'd7, 32'd20);
        end
        repeat (7) @(negedge clk);
        checks++;
        if (outport !== 32'd0) begin
            errors++;
            $display("FAIL branch_final_outport got=%h exp=%h", outport, 32'd0);
        end
        checks++;
        if (dut.regs[5] !== 32'd28) begin
            errors++;
            $display("FAIL jal_link got=%h exp=%h", dut.regs[5], 32'd28);
        end
        checks++;
        if (dut.pc !== 32'd32) begin
            errors++;
            $display("FAIL jal_selfloop_pc got=%h exp=%h", dut.pc, 32'd32);
        end
    endtask

    task automatic test_alu_corners();
        logic [31:0] prog [12];
        prog = '{32'h00900013, 32'h00100193, 32'h40300233, 32'hFE402E23,
                 32'h0041B3B3, 32'hFE702E23, 32'h800002B7, 32'h41F2D313,
                 32'hFE602E23, 32'hFE002E23, 0, 0};
        load_prog(prog);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dut.regs[0] !== 32'd0) begin
            errors++;
            $display("FAIL addi_x0 got=%h exp=%h", dut.regs[0], 32'd0);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (outport !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL sub_wrap got=%h exp=%h", outport, 32'hFFFFFFFF);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (outport !== 32'd1) begin
            errors++;
            $display("FAIL sltu got=%h exp=%h", outport, 32'd1);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (outport !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL srai got=%h exp=%h", outport, 32'hFFFFFFFF);
        end
        @(negedge clk);
        checks++;
        if (outport !== 32'd0) begin
            errors++;
            $display("FAIL sw_x0 got=%h exp=%h", outport, 32'd0);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] prog [12];
        prog = '{32'h00500613, 32'hFEC02E23, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        load_prog(prog);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (outport !== 32'd5) begin
            errors++;
            $display("FAIL async_pre got=%h exp=%h", outport, 32'd5);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outport !== 32'd0 || dut.pc !== 32'd0 || dut.regs[12] !== 32'd0) begin
            errors++;
            $display("FAIL async_reset outport=%h pc=%h x12=%h exp=0/0/0",
                     outport, dut.pc, dut.regs[12]);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (outport !== 32'd5) begin
            errors++;
            $display("FAIL async_rerun got=%h exp=%h", outport, 32'd5);
        end
    endtask

    initial begin
        test_reset();
        test_flash_run();
        test_loop_jalr();
        test_jal_branch();
        test_alu_corners();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/riscv_top.md
# riscv_top

Single-cycle RV32I-subset processor with an on-chip instruction memory loaded through a flash port and a single memory-mapped output register. It is the top-level block of the core: after reset, it fetches and executes one instruction per clock from instruction memory starting at address 0. Simulation and FPGA builds use it directly.

## Interface
- WIDTH, 32, datapath/register/PC width (only 32 supported)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flash_addr  in  WIDTH  byte address of instruction word to load; bits [10:2] used
- flash_data  in  WIDTH  instruction word to load
- flash_en  in  1  write strobe; imem[flash_addr[10:2]] <= flash_data on rising clk edge when high
- outport  out  WIDTH  memory-mapped output register

## Operation
- Instruction memory: 512 x 32, zero-initialised at start of simulation/configuration, not cleared by rst. Synchronous write via flash port, combinational read at pc[10:2]. Flashing is legal during and after reset; a word written at edge N is fetched from edge N onward.
- Register file: 32 x 32. x0 reads 0, writes to x0 are ignored. Two combinational reads, one write per cycle.
- Supported instructions: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, OP-IMM (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI), OP (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND), SW.
- JAL/JALR write pc+4 to rd. JALR target = (rs1+imm) & ~1. Branch/JAL target = pc+imm.
- Arithmetic modulo 2^32. Shift amount uses the low 5 bits. SLT/BLT signed, SLTU/BLTU unsigned.
- SW to effective address 32'hFFFF_FFFC loads rs2 into outport. SW to any other address has no effect.
- Any other opcode, including an all-zero word, executes as NOP: pc+4, no state change.
- PC is 32 bits and wraps modulo 2^32. Fetch ignores pc[31:11] and pc[1:0].

## Timing
- While rst is high: pc=0, all registers=0, outport=0. No instruction is executed.
- One instruction retires per rising edge after rst falls. The first edge with rst low executes imem[0].
- Register writeback, pc update and outport update all occur on the same edge. The result is visible to the next instruction with no hazards.
- Asserting rst mid-run immediately (asynchronously) resets pc, registers and outport. Imem contents are kept.

## Structure
- Package common: opcode enum (7-bit RV32 opcodes), ALU-operation enum, funct3 constants, OUTPORT_ADDR = 32'hFFFF_FFFC, IMEM_WORDS = 512.
- Sub-modules:
  - riscv_alu: combinational; inputs a, b and op; outputs result plus the compare flags used for branches.
  - Register file and immediate decode stay inline in riscv_top.

## Test plan
- Reset: hold rst with flash_en idle → outport=0 and pc=0 throughout. Release with empty imem → pc increments by 4 per cycle (NOP fetch).
- Flash then run: load 0x00500613 (addi a2,x0,5) at 0 and 0xFEC02E23 (sw a2,-4(x0)) at 4, release rst → outport=5 after the second edge and stays 5.
- Loop/JALR wrap: load 0x00c64633 at 0, 0x00160613 at 4, 0xffc00067 at 8 → pc sequence 0,4,8,0xFFFFFFFC,0,4,…; x12 alternates 0,1; x0 stays 0.
- JAL/branch: load addi x1,x0,3; addi x1,x1,-1; bne x1,x0,-4; sw x1,-4(x0) → outport=0 after the loop exits (x1 counts 3→0). A preceding sw of 7 proves the update.
- x0/ALU corner cases:
  - addi x0,x0,9 then sw x0 → outport=0.
  - sub of 0-1 stored → 0xFFFFFFFF.
  - srai of 0x80000000 by 31 → 0xFFFFFFFF.
  - sltu 1<0xFFFFFFFF → 1.
- Async reset mid-run: assert rst between edges after outport=5 → outport=0 and pc=0 immediately. Release → program re-runs from imem without reflashing.
